// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-ported data RAM
// between NUM_CORES MEM stages, one transaction outstanding at a time.
module dmem_arbiter #(
   parameter int NUM_CORES   = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [NUM_CORES-1:0]        req_we,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
   output logic [NUM_CORES-1:0]        req_ready,
   output logic [NUM_CORES-1:0]        rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy
);

   localparam int idx_w = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int cnt_w = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [cnt_w-1:0] cnt_init = cnt_w'(MEM_LATENCY - 1);
   localparam logic [idx_w-1:0] idx_last = idx_w'(NUM_CORES - 1);

   typedef enum logic [1:0] {
      st_idle,
      st_access,
      st_wait,
      st_resp
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [idx_w-1:0]  rr_ptr_q;
   logic [idx_w-1:0]  rr_ptr_d;
   logic [idx_w-1:0]  gnt_q;
   logic [cnt_w-1:0]  cnt_q;
   logic [cnt_w-1:0]  cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   logic              found;
   logic [idx_w-1:0]  win;
   logic              accept;
   logic              capture;

   function automatic logic [idx_w-1:0] wrap_add(
      input logic [idx_w-1:0] base,
      input int               k
   );
      int s;
      s = int'(base) + k;
      if (s >= NUM_CORES) begin
         s = s - NUM_CORES;
      end
      return idx_w'(s);
   endfunction

   // Scan starts at rr_ptr so the core served last is checked last.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!found && req_valid[wrap_add(rr_ptr_q, k)]) begin
            found = 1'b1;
            win   = wrap_add(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      capture   = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      mem_en    = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         st_idle: begin
            busy = 1'b0;
            if (found && rst_n) begin
               accept         = 1'b1;
               req_ready[win] = 1'b1;
               state_d        = st_access;
            end
         end
         st_access: begin
            mem_en  = 1'b1;
            cnt_d   = cnt_init;
            state_d = st_wait;
         end
         st_wait: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = st_resp;
            end else begin
               cnt_d = cnt_q - cnt_w'(1);
            end
         end
         st_resp: begin
            rsp_valid[gnt_q] = 1'b1;
            rr_ptr_d = (gnt_q == idx_last) ? '0
                                           : gnt_q + idx_w'(1);
            state_d  = st_idle;
         end
         default: begin
            state_d = st_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= st_idle;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Request fields are latched at accept; the core may drop them next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            gnt_q   <= win;
            we_q    <= req_we[win];
            addr_q  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(win)*DATA_W +: DATA_W];
         end
         if (capture) begin
            rdata_q <= we_q ? '0 : mem_rdata;
         end
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, hand sequences and random traffic
// checked against a transaction-level model and a latency RAM.
module tb_dmem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int L  = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    rv    = '0;
   logic [N-1:0]    rwe   = '0;
   logic [AW-1:0]   raddr [N];
   logic [DW-1:0]   rwdata [N];
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_total = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = raddr[i];
         req_wdata[i*DW +: DW] = rwdata[i];
      end
   end

   dmem_arbiter #(
      .NUM_CORES  (N),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .MEM_LATENCY(L)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(rv),
      .req_we   (rwe),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   function automatic logic [DW-1:0] init_val(input int idx);
      if (idx == 64) return 32'hDEAD_BEEF;
      return 32'h5A00_0000 ^ DW'(idx * 32'h0001_0203);
   endfunction

   // RAM: 256 words, read data appears L cycles after mem_en, junk otherwise
   logic [DW-1:0] ram [256];
   logic [255:0]  ram_wr = '0;
   logic [DW-1:0] pipe [L];

   function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
      return ram_wr[a[9:2]] ? ram[a[9:2]] : init_val(int'(a[9:2]));
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         ram[mem_addr[9:2]]    <= mem_wdata;
         ram_wr[mem_addr[9:2]] <= 1'b1;
      end
      pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr) : DW'($urandom);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end

   assign mem_rdata = pipe[L-1];

   logic [DW-1:0] ref_mem [int];

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      int idx;
      idx = int'(a[9:2]);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one transaction lives from accept a to a+2+L.
   task automatic monitor();
      bit            act = 1'b0;
      int            cyc = 0;
      int            acc = 0;
      int            g   = 0;
      int            ptr = 0;
      int            c;
      logic          mwe = 1'b0;
      logic [AW-1:0] ma  = '0;
      logic [DW-1:0] mwd = '0;
      logic [DW-1:0] md  = '0;
      logic [N-1:0]  er;
      logic [N-1:0]  ersp;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            act = 1'b0;
            ptr = 0;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_rsp_valid", rsp_valid, '0);
            chk("rst_rsp_rdata", rsp_rdata, '0);
            chk("rst_mem_en", mem_en, '0);
            chk("rst_mem_we", mem_we, '0);
            chk("rst_mem_addr", mem_addr, '0);
            chk("rst_mem_wdata", mem_wdata, '0);
            chk("rst_busy", busy, '0);
         end else begin
            if (act && cyc > acc + 2 + L) act = 1'b0;
            er = '0;
            if (!act) begin
               for (int k = 0; k < N; k++) begin
                  c = (ptr + k) % N;
                  if (er == '0 && rv[c]) er[c] = 1'b1;
               end
            end
            chk("req_ready", req_ready, er);
            chk("mem_en", mem_en, act && cyc == acc + 1);
            if (act && cyc == acc + 1) begin
               chk("mem_we", mem_we, mwe);
               chk("mem_addr", mem_addr, ma);
               if (mwe) chk("mem_wdata", mem_wdata, mwd);
            end
            chk("busy", busy, act && cyc > acc);
            ersp = '0;
            if (act && cyc == acc + 2 + L) ersp[g] = 1'b1;
            chk("rsp_valid", rsp_valid, ersp);
            if (ersp != '0) chk("rsp_rdata", rsp_rdata, md);
            if (er != '0) begin
               for (int k = 0; k < N; k++) if (er[k]) g = k;
               act = 1'b1;
               acc = cyc;
               acc_total++;
               mwe = rwe[g];
               ma  = raddr[g];
               mwd = rwdata[g];
               md  = mwe ? '0 : ref_rd(ma);
               if (mwe) ref_mem[int'(ma[9:2])] = mwd;
               ptr = (g + 1) % N;
            end
         end
      end
   endtask

   typedef struct {
      logic [N-1:0]  mask;
      logic [N-1:0]  we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            ord [4];
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t tbl [9];

   task automatic wait_idle();
      for (int t = 0; t < 30 && busy; t++) step();
      if (busy) tmo("wait_idle");
   endtask

   task automatic run_entry(input vec_t v, input string nm);
      int got;
      int lat;
      wait_idle();
      for (int i = 0; i < N; i++) begin
         if (v.mask[i]) begin
            rv[i]     = 1'b1;
            rwe[i]    = v.we[i];
            raddr[i]  = v.addr;
            rwdata[i] = v.wdata;
         end
      end
      for (int n = 0; n < $countones(v.mask); n++) begin
         got = -1;
         for (int t = 0; t < 40 && got < 0; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
            if (got < 0) step();
         end
         if (got < 0) begin
            tmo({nm, "_accept"});
            rv = '0;
            return;
         end
         chk({nm, "_grant"}, got, v.ord[n]);
         step();
         rv[got] = 1'b0;
         lat = -1;
         for (int t = 1; t <= 40 && lat < 0; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) lat = t;
            else step();
         end
         if (lat < 0) begin
            tmo({nm, "_rsp"});
            rv = '0;
            return;
         end
         chk({nm, "_lat"}, lat, 2 + L);
         chk({nm, "_rsp_core"}, rsp_valid, 1 << got);
         if (n == 0) chk({nm, "_rdata"}, rsp_rdata, v.rdata);
         step();
      end
   endtask

   task automatic new_req(input int i);
      rv[i]     = 1'b1;
      rwe[i]    = 1'($urandom_range(0, 1));
      raddr[i]  = AW'($urandom_range(0, 255)) << 2;
      rwdata[i] = $urandom;
   endtask

   initial begin
      int   exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int   served [N];
      int   nacc;
      int   last_acc;
      int   last_g;
      int   g;
      logic [N-1:0] rdy;

      for (int i = 0; i < N; i++) begin
         raddr[i]  = '0;
         rwdata[i] = '0;
         served[i] = 0;
      end

      tbl[0] = '{4'b0100, 4'b0000, 32'h100, 32'h0,    '{2, 0, 0, 0}, 32'hDEAD_BEEF};
      tbl[1] = '{4'b0010, 4'b0010, 32'h040, 32'h55,   '{1, 0, 0, 0}, 32'h0};
      tbl[2] = '{4'b0100, 4'b0000, 32'h040, 32'h0,    '{2, 0, 0, 0}, 32'h55};
      tbl[3] = '{4'b1000, 4'b0000, 32'h100, 32'h0,    '{3, 0, 0, 0}, 32'hDEAD_BEEF};
      tbl[4] = '{4'b1001, 4'b0000, 32'h040, 32'h0,    '{0, 3, 0, 0}, 32'h55};
      tbl[5] = '{4'b0110, 4'b0110, 32'h080, 32'hA5A5, '{1, 2, 0, 0}, 32'h0};
      tbl[6] = '{4'b1111, 4'b0000, 32'h080, 32'h0,    '{3, 0, 1, 2}, 32'hA5A5};
      tbl[7] = '{4'b1010, 4'b0000, 32'h100, 32'h0,    '{3, 1, 0, 0}, 32'hDEAD_BEEF};
      tbl[8] = '{4'b0011, 4'b0000, 32'h000, 32'h0,    '{0, 1, 0, 0}, 32'h5A00_0000};

      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset held with every core requesting, then continuous traffic
      rv = '1;
      for (int i = 0; i < N; i++) raddr[i] = 32'h300 + AW'(i * 4);
      repeat (3) step();
      rst_n = 1'b1;
      nacc = 0;
      last_acc = 0;
      last_g = 0;
      for (int c = 0; c < 100 && nacc < 8; c++) begin
         @(negedge clk);
         g = -1;
         if (rsp_valid != '0) begin
            chk("cont_rsp_core", rsp_valid, 1 << last_g);
            chk("cont_rsp_lat", c - last_acc, 2 + L);
         end
         for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
         if (g >= 0) begin
            chk("cont_order", g, exp_ord[nacc]);
            if (nacc > 0) chk("cont_spacing", c - last_acc, L + 3);
            last_acc = c;
            last_g = g;
            nacc++;
            served[g]++;
         end
         step();
         if (g >= 0) begin
            if (served[g] >= 2) rv[g] = 1'b0;
            else raddr[g] = raddr[g] + 32'h10;
         end
      end
      if (nacc < 8) tmo("cont_accepts");
      rv = '0;

      for (int e = 0; e < 9; e++) run_entry(tbl[e], $sformatf("tbl%0d", e));

      // Reset while the transaction is waiting on memory
      wait_idle();
      rv[1] = 1'b1;
      rwe[1] = 1'b0;
      raddr[1] = 32'h100;
      g = -1;
      for (int t = 0; t < 20 && g < 0; t++) begin
         @(negedge clk);
         if (req_ready[1]) g = 1;
         else step();
      end
      if (g < 0) tmo("rst6_accept");
      step();
      rv[1] = 1'b0;
      step();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst6_busy", busy, 1'b0);
      chk("rst6_rsp", rsp_valid, '0);
      step();
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk("rst6_no_rsp", rsp_valid, '0);
         step();
      end
      run_entry('{4'b0110, 4'b0000, 32'h100, 32'h0, '{1, 2, 0, 0},
                  32'hDEAD_BEEF}, "rst6_after");

      // Random traffic obeying the hold-until-ready handshake
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         rdy = req_ready;
         step();
         for (int i = 0; i < N; i++) begin
            if (rv[i] && rdy[i]) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
               else rv[i] = 1'b0;
            end else if (!rv[i] && $urandom_range(0, 3) == 0) begin
               new_req(i);
            end
         end
      end
      for (int c = 0; c < 200 && rv != '0; c++) begin
         @(negedge clk);
         rdy = req_ready;
         step();
         rv = rv & ~rdy;
      end
      if (rv != '0) tmo("rand_drain");
      rv = '0;
      wait_idle();
      repeat (2) step();
      chk("rand_activity", acc_total > 50, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
